// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator keypad front end:
// entry-state encodings, operator/key codes and small decode/arithmetic helpers.
package calc_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_AND = 4'hC;
  localparam logic [3:0] OP_OR  = 4'hD;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] KEY_EQ = 4'hF;
  localparam logic [1:0] CLEAR_FLAG = 2'd3;

  // Operator keys share their ALU op code, so the parser can latch the key code directly.
  function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    case ({col, row})
      4'h0: code = 4'd1;
      4'h1: code = 4'd4;
      4'h2: code = 4'd7;
      4'h3: code = 4'd0;
      4'h4: code = 4'd2;
      4'h5: code = 4'd5;
      4'h6: code = 4'd8;
      4'h7: code = KEY_EQ;
      4'h8: code = 4'd3;
      4'h9: code = 4'd6;
      4'hA: code = 4'd9;
      4'hB: code = OP_CMP;
      4'hC: code = OP_ADD;
      4'hD: code = OP_SUB;
      4'hE: code = OP_AND;
      4'hF: code = OP_OR;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] row);
    return {2'd0, ~row[0]} + {2'd0, ~row[1]} + {2'd0, ~row[2]} + {2'd0, ~row[3]};
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] row);
    logic [1:0] idx;
    casez (row)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Decimal shift-in: old*10 + d using only shifts and adds.
  function automatic logic [15:0] acc_digit(input logic [15:0] old, input logic [3:0] d);
    return (old << 3) + (old << 1) + {12'd0, d};
  endfunction

endpackage

// File: rtl/keypad_entry_parser_if.sv
// Keypad matrix and operand/operator bus between the entry parser and the core unit.
interface keypad_entry_parser_if;
  logic [3:0] IN_row;
  logic [3:0] OUT_col;
  logic [7:0] OUT_SRCH;
  logic [7:0] OUT_SRCL;
  logic [7:0] OUT_DSTH;
  logic [7:0] OUT_DSTL;
  logic [3:0] OUT_ALU_OP;
  logic       OUT_finish;
  logic [1:0] OUT_state;
  logic [1:0] OUT_flag;

  modport master (
    input  IN_row,
    output OUT_col, OUT_SRCH, OUT_SRCL, OUT_DSTH, OUT_DSTL,
    output OUT_ALU_OP, OUT_finish, OUT_state, OUT_flag
  );

  modport slave (
    output IN_row,
    input  OUT_col, OUT_SRCH, OUT_SRCL, OUT_DSTH, OUT_DSTL,
    input  OUT_ALU_OP, OUT_finish, OUT_state, OUT_flag
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// Drives the 4x4 keypad columns, classifies each full scan frame and debounces
// presses/releases into a single one-cycle key event per press.
module keypad_scan_debounce
  import calc_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 4
) (
  input  logic       IN_clk,
  input  logic       IN_rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [7:0] DEB_N = 8'(DEB_FRAMES);

  logic [DW-1:0] div_r;
  logic [1:0]    col_idx_r;
  logic [3:0]    col_r, row_meta_r, row_sync_r;
  logic [1:0]    hits_r;
  logic [3:0]    acc_key_r, cand_r, key_code_r;
  logic          released_r, key_valid_r;
  logic [7:0]    cnt_r;

  logic          slot_end_s, frame_end_s;
  logic [2:0]    sum_s;
  logic [1:0]    total_s;
  logic [3:0]    col_key_s, frame_key_s, cand_n_s, key_code_n_s;
  logic [7:0]    run_s, cnt_n_s;
  logic          released_n_s, key_valid_n_s;

  // Frame accumulation: hits saturate at 2 so any multi-key frame reads as invalid.
  always_comb begin
    slot_end_s  = (div_r == DIV_LAST);
    frame_end_s = slot_end_s && (col_idx_r == 2'd3);
    sum_s       = {1'b0, hits_r} + low_count(row_sync_r);
    total_s     = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    col_key_s   = key_lookup(col_idx_r, first_low(row_sync_r));
    frame_key_s = (hits_r != 2'd0) ? acc_key_r : col_key_s;
    run_s       = ((cand_r == frame_key_s) && (cnt_r != 8'd0)) ? cnt_r + 8'd1 : 8'd1;
  end

  // Debounce decision, evaluated only on the cycle a frame completes.
  always_comb begin
    released_n_s  = released_r;
    cand_n_s      = cand_r;
    cnt_n_s       = cnt_r;
    key_valid_n_s = 1'b0;
    key_code_n_s  = key_code_r;
    if (frame_end_s) begin
      case (total_s)
        2'd0: begin
          if (released_r) begin
            cnt_n_s = 8'd0;
          end else if (cnt_r + 8'd1 >= DEB_N) begin
            released_n_s = 1'b1;
            cnt_n_s      = 8'd0;
          end else begin
            cnt_n_s = cnt_r + 8'd1;
          end
        end
        2'd1: begin
          if (!released_r) begin
            cnt_n_s = 8'd0;
          end else if (run_s >= DEB_N) begin
            key_valid_n_s = 1'b1;
            key_code_n_s  = frame_key_s;
            released_n_s  = 1'b0;
            cnt_n_s       = 8'd0;
          end else begin
            cand_n_s = frame_key_s;
            cnt_n_s  = run_s;
          end
        end
        default: cnt_n_s = cnt_r;
      endcase
    end else begin
      cnt_n_s = cnt_r;
    end
  end

  // Column scan, row synchroniser and per-frame accumulators.
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      div_r      <= '0;
      col_idx_r  <= 2'd0;
      col_r      <= 4'b1110;
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
      hits_r     <= 2'd0;
      acc_key_r  <= 4'd0;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
      if (slot_end_s) begin
        div_r     <= '0;
        col_idx_r <= col_idx_r + 2'd1;
        col_r     <= {col_r[2:0], col_r[3]};
        hits_r    <= frame_end_s ? 2'd0 : total_s;
        acc_key_r <= frame_end_s ? 4'd0 : frame_key_s;
      end else begin
        div_r <= div_r + DW'(1);
      end
    end
  end

  // Debounce state and the registered key event.
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      released_r  <= 1'b1;
      cand_r      <= 4'd0;
      cnt_r       <= 8'd0;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
    end else begin
      released_r  <= released_n_s;
      cand_r      <= cand_n_s;
      cnt_r       <= cnt_n_s;
      key_valid_r <= key_valid_n_s;
      key_code_r  <= key_code_n_s;
    end
  end

  assign col       = col_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
endmodule

// File: rtl/keypad_entry_parser.sv
// Keypad front end of the calculator: turns debounced key events into two
// decimal operands, an operator and the entry progress seen by the core unit.
module keypad_entry_parser
  import calc_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 4
) (
  input  logic IN_clk,
  input  logic IN_rst,
  keypad_entry_parser_if.master bus
);
  logic [3:0]  col_s, key_code_s;
  logic        key_valid_s;
  state_t      state_r, state_n_s;
  logic [1:0]  flag_r, flag_n_s;
  logic [15:0] src_r, src_n_s, dst_r, dst_n_s;
  logic [3:0]  op_r, op_n_s;
  logic        fin_r, fin_n_s;
  logic        is_digit_s, is_op_s, is_eq_s;

  keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) u_scan (
    .IN_clk   (IN_clk),
    .IN_rst   (IN_rst),
    .row      (bus.IN_row),
    .col      (col_s),
    .key_valid(key_valid_s),
    .key_code (key_code_s)
  );

  // Entry FSM; finish and clear are one-cycle markers that fall back to idle.
  always_comb begin
    state_n_s  = state_r;
    flag_n_s   = flag_r;
    src_n_s    = src_r;
    dst_n_s    = dst_r;
    op_n_s     = op_r;
    fin_n_s    = 1'b0;
    is_digit_s = (key_code_s <= 4'd9);
    is_op_s    = (key_code_s >= OP_ADD) && (key_code_s <= OP_CMP);
    is_eq_s    = (key_code_s == KEY_EQ);
    if (fin_r) begin
      state_n_s = S0;
      flag_n_s  = 2'd0;
    end else if ((state_r == S0) && (flag_r == CLEAR_FLAG)) begin
      flag_n_s = 2'd0;
    end else if (key_valid_s) begin
      case (state_r)
        S0: begin
          if (is_digit_s) begin
            src_n_s   = {12'd0, key_code_s};
            flag_n_s  = 2'd1;
            state_n_s = S1;
          end else if (is_eq_s) begin
            flag_n_s = CLEAR_FLAG;
            src_n_s  = 16'd0;
            dst_n_s  = 16'd0;
            op_n_s   = 4'd0;
          end else begin
            state_n_s = S0;
          end
        end
        S1: begin
          if (is_digit_s && (flag_r < 2'd3)) begin
            src_n_s  = acc_digit(src_r, key_code_s);
            flag_n_s = flag_r + 2'd1;
          end else if (is_op_s) begin
            op_n_s    = key_code_s;
            state_n_s = S2;
          end else begin
            state_n_s = S1;
          end
        end
        S2: begin
          if (is_digit_s) begin
            dst_n_s   = {12'd0, key_code_s};
            flag_n_s  = 2'd1;
            state_n_s = S3;
          end else if (is_op_s) begin
            op_n_s = key_code_s;
          end else begin
            state_n_s = S2;
          end
        end
        S3: begin
          if (is_digit_s && (flag_r < 2'd3)) begin
            dst_n_s  = acc_digit(dst_r, key_code_s);
            flag_n_s = flag_r + 2'd1;
          end else if (is_eq_s) begin
            fin_n_s = 1'b1;
          end else begin
            state_n_s = S3;
          end
        end
        default: state_n_s = S0;
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Entry registers; these drive the core-unit interface directly.
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      state_r <= S0;
      flag_r  <= 2'd0;
      src_r   <= 16'd0;
      dst_r   <= 16'd0;
      op_r    <= 4'd0;
      fin_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      flag_r  <= flag_n_s;
      src_r   <= src_n_s;
      dst_r   <= dst_n_s;
      op_r    <= op_n_s;
      fin_r   <= fin_n_s;
    end
  end

  assign bus.OUT_col    = col_s;
  assign bus.OUT_SRCH   = src_r[15:8];
  assign bus.OUT_SRCL   = src_r[7:0];
  assign bus.OUT_DSTH   = dst_r[15:8];
  assign bus.OUT_DSTL   = dst_r[7:0];
  assign bus.OUT_ALU_OP = op_r;
  assign bus.OUT_finish = fin_r;
  assign bus.OUT_state  = state_r;
  assign bus.OUT_flag   = flag_r;
endmodule

// File: tb/tb_keypad_entry_parser.sv
// Scoreboard bench for keypad_entry_parser: a keypad matrix model, directed key
// sequences with hand-computed expected output snapshots, and a change monitor.
module tb_keypad_entry_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] keys_down = 16'd0;
  logic [3:0]  row_s;

  keypad_entry_parser_if bus();

  keypad_entry_parser #(.SCAN_DIV(4), .DEB_FRAMES(2)) dut (
    .IN_clk(clk),
    .IN_rst(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key at (col,row) pulls its row low while its column is driven.
  always_comb begin
    row_s = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys_down[c*4+r] && !bus.OUT_col[c]) row_s[r] = 1'b0;
  end
  assign bus.IN_row = row_s;

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  fl;
    logic [15:0] src;
    logic [15:0] dst;
    logic [3:0]  op;
    logic        fin;
  } snap_t;

  typedef struct {
    snap_t s;
    int    hold;
  } exp_t;

  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;
  snap_t prev_snap, cur_snap;
  exp_t  e;
  int    cyc = 0, last_cyc = 0, prev_hold = 0, n_pop = 0;

  function automatic snap_t snap();
    snap_t s;
    s.st  = bus.OUT_state;
    s.fl  = bus.OUT_flag;
    s.src = {bus.OUT_SRCH, bus.OUT_SRCL};
    s.dst = {bus.OUT_DSTH, bus.OUT_DSTL};
    s.op  = bus.OUT_ALU_OP;
    s.fin = bus.OUT_finish;
    return s;
  endfunction

  // Keypad position index (col*4+row) of each key code, from the keypad layout.
  function automatic logic [15:0] km(input logic [3:0] code);
    int idx;
    case (code)
      4'd1: idx = 0;   4'd4: idx = 1;   4'd7: idx = 2;   4'd0: idx = 3;
      4'd2: idx = 4;   4'd5: idx = 5;   4'd8: idx = 6;   4'hF: idx = 7;
      4'd3: idx = 8;   4'd6: idx = 9;   4'd9: idx = 10;  4'hE: idx = 11;
      4'hA: idx = 12;  4'hB: idx = 13;  4'hC: idx = 14;  default: idx = 15;
    endcase
    return 16'd1 << idx;
  endfunction

  task automatic push(input int st, input int fl, input int src, input int dst,
                      input int op, input int fin, input int hold);
    exp_t x;
    x.s.st = 2'(st); x.s.fl = 2'(fl); x.s.src = 16'(src); x.s.dst = 16'(dst);
    x.s.op = 4'(op); x.s.fin = 1'(fin); x.hold = hold;
    exp_q.push_back(x);
  endtask

  task automatic press_mask(input logic [15:0] mask, input int frames);
    keys_down = mask;
    repeat (frames * 16) @(posedge clk);
    keys_down = 16'd0;
    repeat (64) @(posedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    press_mask(km(code), 4);
  endtask

  // Monitor: every change of the output bundle must match the next queued snapshot.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      n_tests++;
      if ($countones(~bus.OUT_col) != 1) begin
        n_fail++;
        $display("FAIL col_onehot: got %b, want exactly one low bit", bus.OUT_col);
      end
      cur_snap = snap();
      if (cur_snap != prev_snap) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got st=%0d fl=%0d src=%h dst=%h op=%h fin=%0d, want no change",
                   cur_snap.st, cur_snap.fl, cur_snap.src, cur_snap.dst, cur_snap.op, cur_snap.fin);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          if (e.s != cur_snap) begin
            n_fail++;
            $display("FAIL snapshot%0d: got st=%0d fl=%0d src=%h dst=%h op=%h fin=%0d, want st=%0d fl=%0d src=%h dst=%h op=%h fin=%0d",
                     n_pop, cur_snap.st, cur_snap.fl, cur_snap.src, cur_snap.dst, cur_snap.op, cur_snap.fin,
                     e.s.st, e.s.fl, e.s.src, e.s.dst, e.s.op, e.s.fin);
          end
          if (prev_hold != 0) begin
            n_tests++;
            if (cyc - last_cyc != prev_hold) begin
              n_fail++;
              $display("FAIL pulse_width%0d: got %0d cycles, want %0d", n_pop, cyc - last_cyc, prev_hold);
            end
          end
          prev_hold = e.hold;
          last_cyc  = cyc;
        end
        prev_snap = cur_snap;
      end
    end
  end

  initial begin
    snap_t zero_snap;
    zero_snap = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (snap() != zero_snap) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want %h", snap(), zero_snap);
    end
    n_tests++;
    if (bus.OUT_col != 4'b1110) begin
      n_fail++;
      $display("FAIL reset_col: got %b, want 1110", bus.OUT_col);
    end
    rst = 1'b0;
    prev_snap = snap();
    mon_en = 1'b1;

    // 12 + 34 = : operands, operator, finish pulse, then idle
    push(1, 1, 1, 0, 0, 0, 0);           press(4'd1);
    push(1, 2, 12, 0, 0, 0, 0);          press(4'd2);
    push(2, 2, 12, 0, 4'hA, 0, 0);       press(4'hA);
    push(3, 1, 12, 3, 4'hA, 0, 0);       press(4'd3);
    push(3, 2, 12, 34, 4'hA, 0, 0);      press(4'd4);
    push(3, 2, 12, 34, 4'hA, 1, 1);
    push(0, 0, 12, 34, 4'hA, 0, 0);      press(4'hF);

    // 999, fourth digit ignored; '=' in s2 ignored
    push(1, 1, 9, 34, 4'hA, 0, 0);       press(4'd9);
    push(1, 2, 99, 34, 4'hA, 0, 0);      press(4'd9);
    push(1, 3, 999, 34, 4'hA, 0, 0);     press(4'd9);
    press(4'd9);
    push(2, 3, 999, 34, 4'hA, 0, 0);     press(4'hA);
    press(4'hF);
    push(3, 1, 999, 1, 4'hA, 0, 0);      press(4'd1);
    push(3, 1, 999, 1, 4'hA, 1, 1);
    push(0, 0, 999, 1, 4'hA, 0, 0);      press(4'hF);

    // 5 - and 7 = : operator replacement in s2
    push(1, 1, 5, 1, 4'hA, 0, 0);        press(4'd5);
    push(2, 1, 5, 1, 4'hB, 0, 0);        press(4'hB);
    push(2, 1, 5, 1, 4'hC, 0, 0);        press(4'hC);
    push(3, 1, 5, 7, 4'hC, 0, 0);        press(4'd7);
    push(3, 1, 5, 7, 4'hC, 1, 1);
    push(0, 0, 5, 7, 4'hC, 0, 0);        press(4'hF);

    // clear in s0
    push(0, 3, 0, 0, 0, 0, 1);
    push(0, 0, 0, 0, 0, 0, 0);           press(4'hF);

    // ignored operator in s0, one-frame chatter, long hold, double presses
    press(4'hA);
    press_mask(km(4'd5), 1);
    push(1, 1, 1, 0, 0, 0, 0);           press(4'd1);
    press(4'hF);
    push(1, 2, 12, 0, 0, 0, 0);          press_mask(km(4'd2), 10);
    press_mask(km(4'd3) | km(4'd6), 6);
    press_mask(km(4'd4) | km(4'd5), 6);
    push(2, 2, 12, 0, 4'hA, 0, 0);       press(4'hA);
    push(3, 1, 12, 3, 4'hA, 0, 0);       press(4'd3);
    press(4'hB);

    // reset in the middle of the second operand
    push(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.OUT_state != 2'd0 || {bus.OUT_SRCH, bus.OUT_SRCL} != 16'd0 || {bus.OUT_DSTH, bus.OUT_DSTL} != 16'd0) begin
      n_fail++;
      $display("FAIL midreset: got st=%0d src=%h dst=%h, want 0 0 0",
               bus.OUT_state, {bus.OUT_SRCH, bus.OUT_SRCL}, {bus.OUT_DSTH, bus.OUT_DSTL});
    end
    rst = 1'b0;
    push(1, 1, 7, 0, 0, 0, 0);           press(4'd7);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending snapshots, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
